decade_seq_monitor: RTL and testbench

//  Receive-side checker for the 4-bit BCD stream driven by decade_counter.

---
 rtl/decade_seq_monitor_if.sv | 25 ++
 rtl/decade_seq_monitor.sv | 110 +++++++++++
 tb/tb_decade_seq_monitor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decade_seq_monitor_if.sv
// Sample strobe, BCD sample and checker status between a BCD stream source and decade_seq_monitor.
// The master drives en/count; the slave (monitor) returns registered status and counters.
interface decade_seq_monitor_if #(
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              en;
    logic [3:0]        count;
    logic              locked;
    logic [3:0]        expected;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;
    logic              illegal;

    modport master (
        output en, count,
        input  locked, expected, err_pulse, err_count, wrap_count, illegal
    );

    modport slave (
        input  en, count,
        output locked, expected, err_pulse, err_count, wrap_count, illegal
    );
endinterface

// File: rtl/decade_seq_monitor.sv
// Locks onto a 0..9 wrapping BCD stream and counts sequence errors, decade wraps and illegal codes.
// One-cycle registered latency per enabled sample; en=0 freezes all state and drops err_pulse.
module decade_seq_monitor #(
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    decade_seq_monitor_if.slave  bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        prev;
    logic [RUN_W-1:0]  run;
    logic              locked_q;
    logic [3:0]        expected_q;
    logic              err_pulse_q;
    logic [ERR_W-1:0]  err_count_q;
    logic [WRAP_W-1:0] wrap_count_q;
    logic              illegal_q;

    // Codes above 9 have no successor, so they yield 0 and never produce a match.
    function automatic logic [3:0] nxt(input logic [3:0] p);
        if (p >= 4'd9)
            return 4'd0;
        else
            return p + 4'd1;
    endfunction

    logic             hit;
    logic [RUN_W-1:0] run_inc;

    assign hit     = (prev <= 4'd9) && (bus.count <= 4'd9) && (bus.count == nxt(prev));
    assign run_inc = run + RUN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev         <= 4'd0;
            run          <= '0;
            locked_q     <= 1'b0;
            expected_q   <= 4'd0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            if (bus.en) begin
                prev       <= bus.count;
                expected_q <= nxt(bus.count);
                if (bus.count > 4'd9)
                    illegal_q <= 1'b1;
                case (state)
                    IDLE: begin
                        run      <= '0;
                        state    <= HUNT;
                        locked_q <= 1'b0;
                    end
                    HUNT: begin
                        if (hit) begin
                            run <= run_inc;
                            if (run_inc == RUN_LOCK) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            if (prev == 4'd9 && bus.count == 4'd0 && wrap_count_q != WRAP_MAX)
                                wrap_count_q <= wrap_count_q + WRAP_W'(1);
                        end else begin
                            err_pulse_q <= 1'b1;
                            if (err_count_q != ERR_MAX)
                                err_count_q <= err_count_q + ERR_W'(1);
                            run      <= '0;
                            state    <= HUNT;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.expected   = expected_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_count_q;
    assign bus.wrap_count = wrap_count_q;
    assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_decade_seq_monitor.sv
// Bench for decade_seq_monitor: a default-width instance and a 2-bit-counter instance share one stream.
module tb_decade_seq_monitor;
    localparam int LOCK_CNT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] count;

    always #5 clk = ~clk;

    decade_seq_monitor_if #(.ERR_W(8), .WRAP_W(16)) ifa ();
    decade_seq_monitor_if #(.ERR_W(2), .WRAP_W(2))  ifb ();

    assign ifa.en    = en;
    assign ifa.count = count;
    assign ifb.en    = en;
    assign ifb.count = count;

    decade_seq_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(8), .WRAP_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    decade_seq_monitor #(.LOCK_CNT(LOCK_CNT), .ERR_W(2), .WRAP_W(2)) u_dut_narrow (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int nvec = 0;
    int nbad = 0;
    int cur  = 0;

    // Reference: remembers the last sample and how many correct steps in a row were seen.
    bit m_started, m_lk, m_ill, m_pulse;
    int m_last, m_streak, m_errs, m_wraps;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic int m_exp();
        return (m_started && m_last <= 9) ? (m_last + 1) % 10 : 0;
    endfunction

    function automatic logic [36:0] obs();
        return {ifa.locked, ifa.expected, ifa.err_pulse, ifa.err_count, ifa.wrap_count,
                ifa.illegal, ifb.err_count, ifb.wrap_count, ifb.locked, ifb.err_pulse};
    endfunction

    function automatic logic [36:0] mdl();
        return {m_lk, 4'(m_exp()), m_pulse, 8'(sat(m_errs, 255)), 16'(sat(m_wraps, 65535)),
                m_ill, 2'(sat(m_errs, 3)), 2'(sat(m_wraps, 3)), m_lk, m_pulse};
    endfunction

    task automatic model_rst();
        m_started = 0; m_lk = 0; m_ill = 0; m_pulse = 0;
        m_last = 0; m_streak = 0; m_errs = 0; m_wraps = 0;
    endtask

    task automatic model_sample(input int c);
        bit good;
        m_pulse = 0;
        good = m_started && m_last <= 9 && c <= 9 && c == (m_last + 1) % 10;
        if (c > 9) m_ill = 1;
        if (!m_started) begin
            m_started = 1;
            m_streak  = 0;
        end else if (m_lk) begin
            if (good) begin
                if (m_last == 9 && c == 0) m_wraps++;
            end else begin
                m_pulse = 1; m_errs++; m_streak = 0; m_lk = 0;
            end
        end else if (good) begin
            m_streak++;
            if (m_streak >= LOCK_CNT) m_lk = 1;
        end else begin
            m_streak = 0;
        end
        m_last = c;
    endtask

    task automatic step(input bit e, input int c);
        en    = e;
        count = 4'(c);
        @(posedge clk);
        if (e) begin
            model_sample(c);
            cur = c;
        end else begin
            m_pulse = 0;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en  = 1'b0;
        repeat (n) @(posedge clk);
        model_rst();
        cur = 0;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2);
        nvec++;
        if (obs() !== 37'd0) begin
            nbad++; $display("FAIL reset_outputs got %h want %h", obs(), 37'd0);
        end
    endtask

    task automatic test_lock_wrap();
        for (int i = 0; i < 12; i++) begin
            step(1, i % 10);
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL lock_seq[%0d] got %h want %h", i, obs(), mdl());
            end
            if (i == 2 || i == 3) begin
                nvec++;
                if (ifa.locked !== (i == 3)) begin
                    nbad++; $display("FAIL lock_latency[%0d] got %0d want %0d", i, ifa.locked, i == 3);
                end
            end
        end
        nvec++;
        if (ifa.wrap_count !== 16'd1 || ifa.err_count !== 8'd0 || ifa.expected !== 4'd2) begin
            nbad++; $display("FAIL lock_wrap got wrap=%0d err=%0d exp=%0d want 1 0 2",
                             ifa.wrap_count, ifa.err_count, ifa.expected);
        end
    endtask

    task automatic test_skip_error();
        int seq[6] = '{2, 3, 5, 6, 7, 8};
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i]);
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL skip_seq[%0d] got %h want %h", i, obs(), mdl());
            end
            if (i == 2) begin
                nvec++;
                if (ifa.err_pulse !== 1'b1 || ifa.err_count !== 8'd1 || ifa.locked !== 1'b0) begin
                    nbad++; $display("FAIL skip_error got pulse=%0d err=%0d lk=%0d want 1 1 0",
                                     ifa.err_pulse, ifa.err_count, ifa.locked);
                end
            end
            if (i == 3) begin
                nvec++;
                if (ifa.err_pulse !== 1'b0) begin
                    nbad++; $display("FAIL skip_pulse_width got %0d want 0", ifa.err_pulse);
                end
            end
        end
        nvec++;
        if (ifa.locked !== 1'b1) begin
            nbad++; $display("FAIL skip_relock got %0d want 1", ifa.locked);
        end
    endtask

    task automatic test_illegal();
        int seq[6] = '{9, 12, 0, 1, 2, 3};
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i]);
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL illegal_seq[%0d] got %h want %h", i, obs(), mdl());
            end
            if (i == 1) begin
                nvec++;
                if (ifa.illegal !== 1'b1 || ifa.err_count !== 8'd2 || ifa.expected !== 4'd0) begin
                    nbad++; $display("FAIL illegal_flag got ill=%0d err=%0d exp=%0d want 1 2 0",
                                     ifa.illegal, ifa.err_count, ifa.expected);
                end
            end
        end
        nvec++;
        if (ifa.locked !== 1'b1 || ifa.illegal !== 1'b1) begin
            nbad++; $display("FAIL illegal_relock got lk=%0d ill=%0d want 1 1", ifa.locked, ifa.illegal);
        end
    endtask

    task automatic test_enable_gap();
        step(1, 4);
        for (int i = 0; i < 4; i++) begin
            step(0, $urandom_range(0, 15));
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL gap_hold[%0d] got %h want %h", i, obs(), mdl());
            end
        end
        step(1, 5);
        nvec++;
        if (ifa.locked !== 1'b1 || ifa.err_pulse !== 1'b0 || ifa.err_count !== 8'd2 || ifa.expected !== 4'd6) begin
            nbad++; $display("FAIL gap_resume got lk=%0d pulse=%0d err=%0d exp=%0d want 1 0 2 6",
                             ifa.locked, ifa.err_pulse, ifa.err_count, ifa.expected);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        for (int e = 0; e < 5; e++) begin
            step(1, (cur + 2) % 10);
            if (ifb.err_pulse === 1'b1) pulses++;
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL sat_err[%0d] got %h want %h", e, obs(), mdl());
            end
            for (int k = 0; k < LOCK_CNT; k++) step(1, (cur + 1) % 10);
        end
        nvec++;
        if (ifb.err_count !== 2'd3 || pulses != 5 || ifa.err_count !== 8'd7) begin
            nbad++; $display("FAIL sat_err_count got narrow=%0d pulses=%0d wide=%0d want 3 5 7",
                             ifb.err_count, pulses, ifa.err_count);
        end
        for (int i = 0; i < 40; i++) step(1, (cur + 1) % 10);
        nvec++;
        if (ifb.wrap_count !== 2'd3 || obs() !== mdl()) begin
            nbad++; $display("FAIL sat_wrap got narrow=%0d snap=%h want 3 snap=%h", ifb.wrap_count, obs(), mdl());
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        nvec++;
        if (obs() !== 37'd0) begin
            nbad++; $display("FAIL midreset_outputs got %h want %h", obs(), 37'd0);
        end
        for (int i = 0; i <= LOCK_CNT; i++) begin
            step(1, i);
            nvec++;
            if (ifa.locked !== (i == LOCK_CNT) || obs() !== mdl()) begin
                nbad++; $display("FAIL midreset_relock[%0d] got lk=%0d snap=%h want lk=%0d snap=%h",
                                 i, ifa.locked, obs(), i == LOCK_CNT, mdl());
            end
        end
    endtask

    task automatic test_random();
        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            int  c;
            bit  e;
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0)
                c = $urandom_range(0, 15);
            else
                c = (cur <= 9) ? (cur + 1) % 10 : 0;
            step(e, c);
            nvec++;
            if (obs() !== mdl()) begin
                nbad++; $display("FAIL random[%0d] en=%0d cnt=%0d got %h want %h", i, e, c, obs(), mdl());
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        count = 4'd0;
        model_rst();
        test_reset();
        test_lock_wrap();
        test_skip_error();
        test_illegal();
        test_enable_gap();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
